// File: rtl/gate_apply_ctrl_pkg.sv
// Shared definitions for the gate-apply sequencer: Q12 constants, FSM states and
// the RAM addresses where the gate tables live.
package gate_apply_ctrl_pkg;

    localparam int Q_FRAC = 12;
    localparam int Q_ONE  = 4096;

    localparam int unsigned GATE_X_BASE = 1000;
    localparam int unsigned GATE_Y_BASE = 1100;
    localparam int unsigned GATE_Z_BASE = 1200;
    localparam int unsigned GATE_H_BASE = 1300;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADV,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gate_apply_ctrl_q_mac.sv
// Signed multiply-accumulate with a double-width accumulator.
// The output is the accumulator floored by FRAC bits and wrapped to DATA_WIDTH.
module gate_apply_ctrl_q_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC       = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int AW2 = 2 * DATA_WIDTH;

    logic signed [AW2-1:0] acc_q;
    logic signed [AW2-1:0] acc_d;
    logic signed [AW2-1:0] prod;

    always_comb begin
        prod  = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
                $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Selecting bits above FRAC is the arithmetic right shift, truncated.
    assign result = acc_q[FRAC +: DATA_WIDTH];

endmodule

// File: rtl/gate_apply_ctrl.sv
// Owns the single-port RAM while applying a DIMxDIM Q12 matrix to a DIM-entry
// vector; passes CPU traffic straight through to the RAM when not busy.
module gate_apply_ctrl
    import gate_apply_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DIM           = 4,
    parameter int FRAC          = Q_FRAC
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] mat_base,
    input  logic [ADDRESS_WIDTH-1:0] vec_src,
    input  logic [ADDRESS_WIDTH-1:0] vec_dst,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_drop,
    input  logic                     cpu_wEn,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
    output logic [DATA_WIDTH-1:0]    cpu_dataOut,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DIM + 1);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   mat_q, mat_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [DW-1:0]   vreg_q [DIM];
    logic [DW-1:0]   vreg_d [DIM];

    logic            mac_clr;
    logic            mac_en;
    logic [DW-1:0]   mac_b;
    logic [DW-1:0]   mac_result;

    gate_apply_ctrl_q_mac #(
        .DATA_WIDTH (DW),
        .FRAC       (FRAC)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (mem_dataOut),
        .b       (mac_b),
        .result  (mac_result)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        mat_d      = mat_q;
        src_d      = src_q;
        dst_d      = dst_q;
        vreg_d     = vreg_q;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        mac_b      = '0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_wEn    = cpu_wEn;
        mem_addr   = cpu_addr;
        mem_dataIn = cpu_dataIn;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mat_d   = mat_base;
                    src_d   = vec_src;
                    dst_d   = vec_dst;
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = ST_LOADV;
                end
            end
            ST_LOADV: begin
                busy     = 1'b1;
                mem_wEn  = 1'b0;
                mem_addr = src_q + AW'(cnt_q);
                // Read data lags the address by one cycle, so slot i fills at cnt i+1.
                for (int i = 0; i < DIM; i++) begin
                    if (cnt_q == CW'(i + 1)) vreg_d[i] = mem_dataOut;
                end
                if (cnt_q == CW'(DIM)) begin
                    cnt_d   = '0;
                    state_d = ST_MAC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MAC: begin
                busy     = 1'b1;
                mem_wEn  = 1'b0;
                mem_addr = mat_q + AW'(row_q) * AW'(DIM) + AW'(cnt_q);
                mac_clr  = (cnt_q == '0);
                mac_en   = (cnt_q != '0);
                for (int i = 0; i < DIM; i++) begin
                    if (cnt_q == CW'(i + 1)) mac_b = vreg_q[i];
                end
                if (cnt_q == CW'(DIM)) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WRITE: begin
                busy       = 1'b1;
                mem_wEn    = 1'b1;
                mem_addr   = dst_q + AW'(row_q);
                mem_dataIn = mac_result;
                if (row_q == RW'(DIM - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_drop    = busy & cpu_wEn;
    assign cpu_dataOut = mem_dataOut;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            mat_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            for (int i = 0; i < DIM; i++) vreg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            mat_q   <= mat_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            vreg_q  <= vreg_d;
        end
    end

endmodule

// File: tb/tb_gate_apply_ctrl.sv
// Bench for gate_apply_ctrl: behavioural RAM behind the mem port, expected row
// writes queued at start and checked as the sequencer writes them.
module tb_gate_apply_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] mat_base, vec_src, vec_dst;
    logic        busy, done, cpu_drop;
    logic        cpu_wEn;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_dataIn, cpu_dataOut;
    logic        mem_wEn;
    logic [11:0] mem_addr;
    logic [31:0] mem_dataIn, mem_dataOut;

    logic [31:0] ram [0:4095];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    logic [31:0] v  [4];
    logic [31:0] v2 [4];
    int gbase [4] = '{1000, 1100, 1200, 1300};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wEn) ram[mem_addr] <= mem_dataIn;
        mem_dataOut <= ram[mem_addr];
    end

    gate_apply_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mat_base    (mat_base),
        .vec_src     (vec_src),
        .vec_dst     (vec_dst),
        .busy        (busy),
        .done        (done),
        .cpu_drop    (cpu_drop),
        .cpu_wEn     (cpu_wEn),
        .cpu_addr    (cpu_addr),
        .cpu_dataIn  (cpu_dataIn),
        .cpu_dataOut (cpu_dataOut),
        .mem_wEn     (mem_wEn),
        .mem_addr    (mem_addr),
        .mem_dataIn  (mem_dataIn),
        .mem_dataOut (mem_dataOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Gate tables are 2x2 gates tensored with a 2x2 identity (Y stored as real -iY).
    function automatic int gate_elem(input int g, input int r, input int c);
        int a;
        case (g)
            0:       a = ((r / 2) != (c / 2)) ? 4096 : 0;
            1:       a = ((r / 2) == (c / 2)) ? 0 : (((r / 2) == 0) ? -4096 : 4096);
            2:       a = ((r / 2) == (c / 2)) ? (((r / 2) == 0) ? 4096 : -4096) : 0;
            default: a = ((r / 2) == 1 && (c / 2) == 1) ? -2896 : 2896;
        endcase
        if ((r % 2) != (c % 2)) a = 0;
        return a;
    endfunction

    function automatic logic [31:0] model_row(input int g, input int r, input logic [31:0] vv [4]);
        longint acc = 0;
        logic [63:0] t;
        for (int c = 0; c < 4; c++)
            acc += longint'(gate_elem(g, r, c)) * longint'(signed'(vv[c]));
        t = acc >>> 12;
        return t[31:0];
    endfunction

    task automatic cpu_wr(input int a, input logic [31:0] d);
        cpu_wEn    = 1'b1;
        cpu_addr   = 12'(a);
        cpu_dataIn = d;
        @(posedge clk); #1;
        cpu_wEn = 1'b0;
        chk("cpu_wr", ram[a], d);
    endtask

    task automatic load_vec(input int src);
        for (int i = 0; i < 4; i++) cpu_wr(src + i, v[i]);
    endtask

    task automatic run_op(input int g, input int src, input int dst, input int nrows,
                          input int drop_cyc, input int restart_cyc, input int reset_cyc);
        int n;
        exp_t e;
        for (int r = 0; r < nrows; r++) begin
            e.addr = 12'(dst + r);
            e.data = model_row(g, r, v);
            exp_q.push_back(e);
        end
        start    = 1'b1;
        mat_base = 12'(gbase[g]);
        vec_src  = 12'(src);
        vec_dst  = 12'(dst);
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 40) begin
            cpu_wEn    = (n == drop_cyc);
            cpu_addr   = 12'd3000;
            cpu_dataIn = 32'hDEAD0000;
            start      = (n == restart_cyc);
            mat_base   = (n == restart_cyc) ? 12'd1200 : 12'(gbase[g]);
            if (n == reset_cyc) begin
                reset_n = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                reset_n = 1'b1;
                break;
            end
            #1;
            if (n == drop_cyc) chk("cpu_drop", cpu_drop, 1'b1);
            if (n == 2) chk("busy_mid", busy, 1'b1);
            if (mem_wEn) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL unexpected_write observed=%h expected=none", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", mem_dataIn, e.data);
                end
            end
            if (done) break;
            @(posedge clk); #1;
            n++;
        end
        cpu_wEn = 1'b0;
        start   = 1'b0;
        if (reset_cyc == 0) chk("done_cycle", n, 30);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int dcount;
        reset_n    = 1'b0;
        start      = 1'b0;
        mat_base   = '0;
        vec_src    = '0;
        vec_dst    = '0;
        cpu_wEn    = 1'b0;
        cpu_addr   = '0;
        cpu_dataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_drop", cpu_drop, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int g = 0; g < 4; g++)
            for (int i = 0; i < 16; i++)
                cpu_wr(gbase[g] + i, 32'(gate_elem(g, i / 4, i % 4)));

        cpu_addr = 12'd1002;
        @(posedge clk); #1;
        chk("cpu_read", cpu_dataOut, 32'd4096);
        cpu_wr(3000, 32'h0000_1234);

        // X with a dropped CPU write and an ignored second start
        v = '{32'd4096, 32'd0, 32'd0, 32'd0};
        load_vec(2000);
        run_op(0, 2000, 2100, 4, 3, 10, 0);
        chk("drop_ram", ram[3000], 32'h0000_1234);
        chk("x_out2", ram[2102], 32'd4096);
        chk("x_out0", ram[2100], 32'd0);

        // Z on a negative result
        v = '{32'd0, 32'd0, 32'd4096, 32'd0};
        load_vec(2010);
        run_op(2, 2010, 2110, 4, 0, 0, 0);
        chk("z_out2", ram[2112], 32'hFFFF_F000);

        // H twice in place
        v = '{32'd4096, 32'd0, 32'd0, 32'd0};
        load_vec(2020);
        run_op(3, 2020, 2020, 4, 0, 0, 0);
        chk("h1_out0", ram[2020], 32'd2896);
        chk("h1_out2", ram[2022], 32'd2896);
        for (int r = 0; r < 4; r++) v2[r] = model_row(3, r, v);
        v = v2;
        run_op(3, 2020, 2020, 4, 0, 0, 0);
        chk("h2_out0", ram[2020], 32'd4095);
        chk("h2_out2", ram[2022], 32'd0);

        // Reset in the middle of the second row
        v = '{32'd4096, 32'd0, 32'd0, 32'd0};
        load_vec(2030);
        for (int i = 0; i < 4; i++) cpu_wr(2200 + i, 32'h77);
        run_op(0, 2030, 2200, 1, 0, 0, 15);
        chk("rst_row0", ram[2200], 32'd0);
        chk("rst_row1", ram[2201], 32'h77);
        dcount = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("rst_no_done", dcount, 0);

        // Destination wraps past the top of the address space
        cpu_wr(4094, 32'h55);
        cpu_wr(4095, 32'h55);
        cpu_wr(0, 32'h55);
        cpu_wr(1, 32'h55);
        v = '{32'd4096, 32'd0, 32'd0, 32'd0};
        load_vec(2040);
        run_op(0, 2040, 4094, 4, 0, 0, 0);
        chk("wrap_4094", ram[4094], 32'd0);
        chk("wrap_4095", ram[4095], 32'd0);
        chk("wrap_0", ram[0], 32'd4096);
        chk("wrap_1", ram[1], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
